// File: rtl/puzzle_2_1_if.sv
// Request/completion bundle for the invalid-ID range scanner.
// The host drives a range in; the scanner reports completion and the running sum.
interface puzzle_2_1_if;
    logic        wr_en;
    logic [63:0] id1;
    logic [63:0] id2;
    logic        valid;
    logic [63:0] sum;

    modport master (output wr_en, id1, id2, input valid, sum);
    modport slave  (input wr_en, id1, id2, output valid, sum);
endinterface

// File: rtl/puzzle_2_1.sv
// Streaming range scanner: sums IDs whose decimal digits are a repeated block,
// one inclusive range per request, accumulated since reset.
module puzzle_2_1 #(
    parameter int REPEAT_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    puzzle_2_1_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CONV, SCAN, DONE} state_t;

    state_t      state, state_next;
    logic [63:0] cand;
    logic [63:0] end_reg;
    logic [63:0] bin_sh;
    logic [63:0] sum_reg;
    logic [79:0] bcd;
    logic [79:0] bcd_adj;
    logic [79:0] bcd_inc;
    logic [5:0]  shift_cnt;
    logic        done_hold;
    logic        accept;
    logic        empty_req;
    logic        last_cand;
    logic        valid_int;
    logic        invalid;
    logic        match;
    logic        carry;
    logic [4:0]  num_digits;
    logic [3:0]  digit [20];

    assign empty_req = bus.id1 > bus.id2;
    assign last_cand = cand == end_reg;
    assign bus.valid = valid_int;
    assign bus.sum   = sum_reg;

    // Double-dabble pre-shift adjust and the decimal +1 carry chain share one walk over the digits.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        bcd_adj = bcd;
        bcd_inc = bcd;
        carry   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            digit[i] = bcd[4*i +: 4];
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // For every possible length d and proper divisor period p, test periodicity;
    // only the length matching the candidate's actual digit count can flag it.
    always_comb begin
        num_digits = 5'd1;
        invalid    = 1'b0;
        match      = 1'b0;
        for (int i = 0; i < 20; i++)
            if (digit[i] != 4'd0) num_digits = 5'(i + 1);
        for (int d = 2; d <= 20; d++) begin
            for (int p = 1; p < d; p++) begin
                if ((d % p) == 0 && (REPEAT_MODE != 0 || 2 * p == d)) begin
                    match = 1'b1;
                    for (int i = 0; i + p < d; i++)
                        if (digit[i] != digit[i + p]) match = 1'b0;
                    if (match && int'(num_digits) == d) invalid = 1'b1;
                end
            end
        end
    end

    // An empty range spends one hidden cycle in DONE so its completion arrives one edge after acceptance.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        valid_int  = 1'b0;
        case (state)
            IDLE: accept = bus.wr_en;
            CONV: if (shift_cnt == 6'd63) state_next = SCAN;
            SCAN: if (last_cand) state_next = DONE;
            DONE: begin
                if (!done_hold) begin
                    valid_int  = 1'b1;
                    accept     = bus.wr_en;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (accept)
            state_next = empty_req ? DONE : CONV;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sum_reg   <= '0;
            done_hold <= 1'b0;
        end else begin
            state     <= state_next;
            done_hold <= accept && empty_req;
            if (state == SCAN && invalid)
                sum_reg <= sum_reg + cand;
        end
    end

    // NOTE: the datapath carries no reset; it is always reloaded on accept before the FSM reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            cand      <= bus.id1;
            end_reg   <= bus.id2;
            bin_sh    <= bus.id1;
            bcd       <= '0;
            shift_cnt <= '0;
        end else if (state == CONV) begin
            bcd       <= {bcd_adj[78:0], bin_sh[63]};
            bin_sh    <= {bin_sh[62:0], 1'b0};
            shift_cnt <= shift_cnt + 6'd1;
        end else if (state == SCAN && !last_cand) begin
            cand <= cand + 64'd1;
            bcd  <= bcd_inc;
        end
    end

endmodule

// File: tb/tb_puzzle_2_1.sv
// Scoreboard bench: both repeat modes run in lockstep on the same requests and are
// compared against a string-based model of repeated-block IDs.
module tb_puzzle_2_1;

    typedef struct {
        longint unsigned sum0;
        longint unsigned sum1;
        int              cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [63:0]     id1;
    logic [63:0]     id2;
    int              cyc = 0;
    int              n_checks = 0;
    int              n_pass = 0;
    longint unsigned mdl_sum0 = 0;
    longint unsigned mdl_sum1 = 0;
    exp_t            exp_q[$];
    exp_t            mon_e;

    longint unsigned std_lo [11] = '{64'd11, 64'd95, 64'd998, 64'd1188511880, 64'd222220, 64'd1698522,
                                     64'd446443, 64'd38593856, 64'd565653, 64'd824824821, 64'd2121212118};
    longint unsigned std_hi [11] = '{64'd22, 64'd115, 64'd1012, 64'd1188511890, 64'd222224, 64'd1698528,
                                     64'd446449, 64'd38593862, 64'd565659, 64'd824824827, 64'd2121212124};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    puzzle_2_1_if bus0 ();
    puzzle_2_1_if bus1 ();

    assign bus0.wr_en = wr_en;
    assign bus0.id1   = id1;
    assign bus0.id2   = id2;
    assign bus1.wr_en = wr_en;
    assign bus1.id1   = id1;
    assign bus1.id2   = id2;

    puzzle_2_1 #(.REPEAT_MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    puzzle_2_1 #(.REPEAT_MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // An ID is invalid if its decimal string equals some shorter prefix block written out d/p times.
    function automatic bit is_invalid(input longint unsigned n, input int mode);
        string s, blk, rep;
        int    d;
        s = $sformatf("%0d", n);
        d = s.len();
        for (int p = 1; p < d; p++) begin
            if (d % p != 0) continue;
            if (mode == 0 && 2 * p != d) continue;
            blk = s.substr(0, p - 1);
            rep = "";
            for (int k = 0; k < d / p; k++) rep = {rep, blk};
            if (rep == s) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic longint unsigned pow10(input int k);
        longint unsigned r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    // Called at a negedge while the DUTs can accept; the following posedge is the accepting edge.
    task automatic issue(input longint unsigned a, input longint unsigned b);
        exp_t            e;
        longint unsigned n;
        if (a <= b) begin
            n = a;
            while (1) begin
                if (is_invalid(n, 0)) mdl_sum0 += n;
                if (is_invalid(n, 1)) mdl_sum1 += n;
                if (n == b) break;
                n++;
            end
            e.cyc = cyc + 1 + 64 + int'(b - a + 1);
        end else begin
            e.cyc = cyc + 1 + 1;
        end
        e.sum0 = mdl_sum0;
        e.sum1 = mdl_sum1;
        exp_q.push_back(e);
        wr_en = 1'b1;
        id1   = a;
        id2   = b;
        @(negedge clk);
        wr_en = 1'b0;
        id1   = {$urandom, $urandom};
        id2   = {$urandom, $urandom};
        check("valid_low_after_accept", {62'd0, bus0.valid, bus1.valid}, 64'd0);
    endtask

    task automatic wait_valid(input int limit);
        int t = 0;
        while (!bus0.valid && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("wait_valid_in_time", 64'(t < limit), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        mdl_sum0 = 0;
        mdl_sum1 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every completion pops one expectation and checks timing and both sums.
    always @(negedge clk) begin
        if (!reset && (bus0.valid || bus1.valid)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {62'd0, bus0.valid, bus1.valid}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("valid_both_modes", {62'd0, bus0.valid, bus1.valid}, 64'd3);
                check("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("sum_mode0", bus0.sum, mon_e.sum0);
                check("sum_mode1", bus1.sum, mon_e.sum1);
            end
        end
    end

    initial begin
        longint unsigned lo, hi, b, maxv;
        int              k;
        bit              seen;

        maxv  = '1;
        reset = 1'b1;
        wr_en = 1'b0;
        id1   = '0;
        id2   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_valid", {62'd0, bus0.valid, bus1.valid}, 64'd0);
            check("idle_sum", bus0.sum | bus1.sum, 64'd0);
        end

        // Single ranges from a clean reset.
        issue(95, 115);
        wait_valid(1000);
        check("m0_95_115", bus0.sum, 64'd99);
        check("m1_95_115", bus1.sum, 64'd210);
        do_reset();
        issue(998, 1012);
        wait_valid(1000);
        check("m0_998_1012", bus0.sum, 64'd1010);
        check("m1_998_1012", bus1.sum, 64'd2009);

        // Standard set, each request issued during the previous valid cycle.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            issue(std_lo[i], std_hi[i]);
            wait_valid(1000);
            if (i == 0) check("m0_after_r0", bus0.sum, 64'd33);
            if (i == 1) check("m0_after_r1", bus0.sum, 64'd132);
            if (i == 2) check("m0_after_r2", bus0.sum, 64'd1142);
        end
        check("m0_standard_total", bus0.sum, 64'd1227775554);
        check("m1_standard_total", bus1.sum, 64'd4174379265);

        // Single-ID range, empty range, and requests pulsed mid-operation.
        do_reset();
        issue(6464, 6464);
        wait_valid(1000);
        check("m0_6464", bus0.sum, 64'd6464);
        check("m1_6464", bus1.sum, 64'd6464);
        issue(10, 5);
        wait_valid(10);
        check("empty_keeps_sum", bus0.sum, 64'd6464);
        @(negedge clk);
        issue(1000, 1100);
        repeat (20) @(negedge clk);
        wr_en = 1'b1; id1 = 0; id2 = 9999999;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (70) @(negedge clk);
        wr_en = 1'b1; id1 = 7; id2 = 3;
        @(negedge clk);
        wr_en = 1'b0;
        wait_valid(1000);
        repeat (80) @(negedge clk);
        check("no_pending_after_ignored", 64'(exp_q.size()), 64'd0);

        // Range ending at the largest 64-bit value must still terminate.
        issue(maxv - 20, maxv);
        wait_valid(1000);
        @(negedge clk);

        // Randomized ranges with random gaps between requests.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    lo = $urandom_range(0, 3000);
                    hi = lo + $urandom_range(0, 25);
                end
                1: begin
                    k  = $urandom_range(1, 6);
                    b  = pow10(k - 1) + $urandom_range(0, 32'(pow10(k) - pow10(k - 1) - 1));
                    lo = b * (pow10(k) + 1) - $urandom_range(0, 8);
                    hi = lo + $urandom_range(0, 15);
                end
                2: begin
                    k  = $urandom_range(1, 4);
                    b  = pow10(k - 1) + $urandom_range(0, 32'(pow10(k) - pow10(k - 1) - 1));
                    lo = b * (pow10(2 * k) + pow10(k) + 1) - $urandom_range(0, 8);
                    hi = lo + $urandom_range(0, 15);
                end
                3: begin
                    lo = {$urandom, $urandom};
                    if (lo > maxv - 30) lo = maxv - 30;
                    hi = lo + $urandom_range(0, 25);
                end
                default: begin
                    lo = $urandom_range(100, 5000);
                    hi = lo - $urandom_range(1, 50);
                end
            endcase
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(lo, hi);
            wait_valid(1000);
        end

        // Reset in the middle of a long scan discards it completely.
        @(negedge clk);
        issue(0, 500);
        repeat (100) @(negedge clk);
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus0.valid || bus1.valid) seen = 1'b1;
        end
        check("no_valid_after_reset", 64'(seen), 64'd0);
        check("m0_sum_after_reset", bus0.sum, 64'd0);
        check("m1_sum_after_reset", bus1.sum, 64'd0);
        issue(11, 22);
        wait_valid(1000);
        check("m0_fresh_11_22", bus0.sum, 64'd33);
        check("m1_fresh_11_22", bus1.sum, 64'd33);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/puzzle_2_1.md
# puzzle_2_1

Streaming range scanner that sums "invalid" product IDs over inclusive decimal ranges, one range per request. An ID is invalid when its decimal digit string is formed by repeating a shorter digit block. The sum accumulates across all ranges since reset. The block sits behind a simple `wr_en` request / `valid` completion handshake driven by a host or bench.

## Interface
- `REPEAT_MODE`, default 0: selects the invalid-ID rule.
  - 0: the digit block is repeated exactly twice (e.g. 55, 6464, 123123).
  - 1: the digit block is repeated two or more times (e.g. 111, 121212).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: one-cycle request; captures `id1`/`id2`.
- `id1`, input, 64: range start, unsigned, inclusive.
- `id2`, input, 64: range end, unsigned, inclusive.
- `valid`, output, 1: one-cycle pulse when the current range is finished.
- `sum`, output, 64: running total of invalid IDs; driven directly from internal register `sum_reg`.

## Operation
- **States:** IDLE, CONV, SCAN, DONE.
- **Request acceptance:**
  - `wr_en` is accepted only in IDLE or DONE. Accepting in DONE is mandatory so back-to-back requests issued right after `valid` are not lost.
  - `wr_en` in CONV or SCAN is ignored.
- **On accept:**
  - Latch `id1` into the binary candidate counter and `id2` into the end register.
  - If `id1` > `id2`, go to DONE (empty range, nothing added).
  - Otherwise go to CONV.
- **CONV:** iterative double-dabble converts the candidate to 20 BCD digits. One shift per cycle, exactly 64 cycles, then go to SCAN.
- **SCAN:** each cycle evaluates one candidate n:
  - If n is invalid, add n to `sum_reg`.
  - If n == `id2`, go to DONE.
  - Otherwise increment the binary counter and the BCD counter (decimal carry chain) in lockstep.
- **DONE:** `valid` = 1 for exactly one cycle. Go to IDLE, or to CONV/DONE if `wr_en` is accepted in that cycle.
- **Digit count:** d = index of the most significant nonzero BCD digit + 1. n = 0 has d = 1 and is never invalid.
- **Mode 0 rule:** n is invalid iff d is even and digits[d/2-1:0] == digits[d-1:d/2].
- **Mode 1 rule:** n is invalid iff some period p, with 1 ≤ p < d and p dividing d, satisfies digit[i] == digit[i+p] for all i < d-p.
- Each n is counted at most once.
- **Arithmetic:** `sum_reg` is 64-bit unsigned and wraps modulo 2^64.
- `id2` = 2^64-1 must terminate correctly: the equality test precedes the increment.
- **Reset:** any state returns to IDLE with `sum_reg` = 0 and `valid` = 0, including mid-CONV or mid-SCAN. Any in-progress range is discarded.

## Timing
- Reset values: `valid` = 0, `sum` = 0, state IDLE.
- Let E0 be the edge accepting `wr_en`, and N = `id2` - `id1` + 1.
  - Edges E1..E64: CONV.
  - Edges E65..E(64+N): SCAN, one candidate each.
  - `valid` is high for the cycle following edge E(64+N).
  - Total latency is 64+N edges.
- Empty range (`id1` > `id2`): `valid` is high after E1.
- `sum` already includes the whole range in the cycle `valid` is high. `sum` changes only on SCAN edges that find an invalid ID.
- `valid` is low in the cycle after E0. A bench polling `valid` right after dropping `wr_en` must see 0.
- `id1`/`id2` need only be stable at E0.

## Test plan
- **Reset then idle:** `reset` for 2 cycles, then idle 10 cycles -> `valid` = 0 and `sum` = 0 throughout.
- **Mode 0, small ranges back to back:**
  - Range 11-22 -> `valid` after 76 edges, `sum` = 33.
  - Next 95-115 -> `sum` = 132.
  - Next 998-1012 -> `sum` = 1142.
  - Each next `wr_en` is issued the cycle after `valid`; none may be dropped.
- **Mode 0, standard example:** full set 11-22, 95-115, 998-1012, 1188511880-1188511890, 222220-222224, 1698522-1698528, 446443-446449, 38593856-38593862, 565653-565659, 824824821-824824827, 2121212118-2121212124 -> final `sum` = 1227775554.
- **Mode 1, same ranges:**
  - 95-115 alone gives 210.
  - 998-1012 alone gives 2009.
  - The full set gives 4174379265.
- **Edge cases:**
  - `id1` = `id2` = 6464 -> +6464 after 65 edges.
  - `id1` = 10, `id2` = 5 -> `valid` after 1 edge, `sum` unchanged.
  - `wr_en` pulsed mid-SCAN -> ignored, result unchanged.
- **Reset mid-SCAN:** assert `reset` during a long range -> `sum` = 0 and no `valid`. A new request then behaves as if the block had just left reset.
